// File: rtl/pipe_stage_fifo.sv
// pipe_stage_fifo
// Elastic in-order buffer sitting between two CPU pipeline stages. It holds up
// to DEPTH stage records and uses a valid/ready handshake on both sides. A
// single-cycle flush discards everything for branch/jump redirects.
// in_ready, out_valid and out_data depend only on stored state. There is no
// combinational path from the upstream inputs to the downstream outputs.
module pipe_stage_fifo #(
   parameter  int WIDTH = 97,
   parameter  int DEPTH = 2,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   input  logic             flush,
   output logic [CW-1:0]    count
);

   // Pointer width. DEPTH >= 2, so this is at least one bit.
   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    cnt_q;
   logic             push;
   logic             pop;

   // Advance a pointer with an explicit wrap at DEPTH-1. DEPTH need not be a
   // power of two, so modulo-2^n rollover would land on unused slots.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      logic [PW-1:0] r;
      if (p == PW'(DEPTH - 1)) r = '0;
      else                     r = p + 1'b1;
      return r;
   endfunction

   // Handshake status comes only from the occupancy register. A slot freed by
   // a pop therefore becomes writable one cycle later. A push into an empty
   // buffer shows up on the output one cycle later.
   assign in_ready  = (cnt_q != CW'(DEPTH));
   assign out_valid = (cnt_q != '0);
   assign count     = cnt_q;

   // Flush wins over both sides of the handshake in its cycle.
   assign push = in_valid  & in_ready  & ~flush;
   assign pop  = out_valid & out_ready & ~flush;

   // The head entry is presented only while valid. The bus reads zero when empty.
   assign out_data = out_valid ? mem[rd_ptr] : '0;

   // Storage write. Reset clears the records. Flush leaves them in place,
   // because the zeroed pointers and count already make them unreachable.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (push) begin
         mem[wr_ptr] <= in_data;
      end
   end

   // Write pointer: moves on each accepted push and returns to slot 0 on flush.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)     wr_ptr <= '0;
      else if (flush) wr_ptr <= '0;
      else if (push)  wr_ptr <= ptr_inc(wr_ptr);
   end

   // Read pointer: moves on each consumed head and returns to slot 0 on flush.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)     rd_ptr <= '0;
      else if (flush) rd_ptr <= '0;
      else if (pop)   rd_ptr <= ptr_inc(rd_ptr);
   end

   // Occupancy: +1 on push only, -1 on pop only, unchanged when both or neither.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else if (flush) begin
         cnt_q <= '0;
      end else begin
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: tb/tb_pipe_stage_fifo.sv
// Directed bench for pipe_stage_fifo. It runs a DEPTH=2 instance at the default
// width and a DEPTH=3 instance for pointer wrap. Inputs change and outputs are
// sampled on the falling edge. State changes on the rising edge.
module tb_pipe_stage_fifo;

   logic clk = 1'b0;
   logic reset = 1'b0;

   // DEPTH=2, WIDTH=97 instance
   logic        iv2 = 1'b0, or2 = 1'b0, fl2 = 1'b0;
   logic [96:0] id2 = '0;
   logic        ir2, ov2;
   logic [96:0] od2;
   logic [1:0]  cnt2;

   // DEPTH=3, WIDTH=16 instance
   logic        iv3 = 1'b0, or3 = 1'b0, fl3 = 1'b0;
   logic [15:0] id3 = '0;
   logic        ir3, ov3;
   logic [15:0] od3;
   logic [1:0]  cnt3;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   pipe_stage_fifo #(.WIDTH(97), .DEPTH(2)) u_d2 (
      .clk(clk), .reset(reset),
      .in_valid(iv2), .in_ready(ir2), .in_data(id2),
      .out_valid(ov2), .out_ready(or2), .out_data(od2),
      .flush(fl2), .count(cnt2)
   );

   pipe_stage_fifo #(.WIDTH(16), .DEPTH(3)) u_d3 (
      .clk(clk), .reset(reset),
      .in_valid(iv3), .in_ready(ir3), .in_data(id3),
      .out_valid(ov3), .out_ready(or3), .out_data(od3),
      .flush(fl3), .count(cnt3)
   );

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_cmp++; if (ir2 !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", ir2); end
      n_cmp++; if (ov2 !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", ov2); end
      n_cmp++; if (od2 !== 97'h0) begin n_err++; $display("FAIL reset_out_data: got %h want 0", od2); end
      n_cmp++; if (cnt2 !== 2'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", cnt2); end
      n_cmp++; if (cnt3 !== 2'd0 || ir3 !== 1'b1) begin n_err++; $display("FAIL reset_d3: got count %0d ready %b want 0 1", cnt3, ir3); end
      reset = 1'b1;
   endtask

   // Push A=1 and B=2 with out_ready low. A appears one cycle after its push.
   task automatic test_fill();
      @(negedge clk); iv2 = 1'b1; id2 = 97'h1; or2 = 1'b0;
      @(negedge clk);
      n_cmp++; if (cnt2 !== 2'd1 || od2 !== 97'h1 || ov2 !== 1'b1) begin n_err++; $display("FAIL fill_first: got count %0d data %h valid %b want 1 1 1", cnt2, od2, ov2); end
      id2 = 97'h2;
      @(negedge clk);
      n_cmp++; if (cnt2 !== 2'd2) begin n_err++; $display("FAIL fill_count: got %0d want 2", cnt2); end
      n_cmp++; if (ir2 !== 1'b0) begin n_err++; $display("FAIL fill_in_ready: got %b want 0", ir2); end
      n_cmp++; if (od2 !== 97'h1) begin n_err++; $display("FAIL fill_head: got %h want 1", od2); end
      iv2 = 1'b0;
   endtask

   // While full, offer C=3 and pop A. C is refused, then accepted next cycle.
   task automatic test_full_pop();
      @(negedge clk); iv2 = 1'b1; id2 = 97'h3; or2 = 1'b1;
      @(negedge clk);
      n_cmp++; if (cnt2 !== 2'd1) begin n_err++; $display("FAIL fullpop_count: got %0d want 1", cnt2); end
      n_cmp++; if (od2 !== 97'h2) begin n_err++; $display("FAIL fullpop_head: got %h want 2", od2); end
      n_cmp++; if (ir2 !== 1'b1) begin n_err++; $display("FAIL fullpop_ready: got %b want 1", ir2); end
      or2 = 1'b0;
      @(negedge clk);
      n_cmp++; if (cnt2 !== 2'd2 || od2 !== 97'h2) begin n_err++; $display("FAIL fullpop_accept: got count %0d head %h want 2 2", cnt2, od2); end
      iv2 = 1'b0; or2 = 1'b1;
      @(negedge clk);
      n_cmp++; if (cnt2 !== 2'd1 || od2 !== 97'h3) begin n_err++; $display("FAIL fullpop_c_head: got count %0d head %h want 1 3", cnt2, od2); end
      @(negedge clk);
      n_cmp++; if (cnt2 !== 2'd0 || ov2 !== 1'b0 || od2 !== 97'h0) begin n_err++; $display("FAIL fullpop_empty: got count %0d valid %b data %h want 0 0 0", cnt2, ov2, od2); end
      or2 = 1'b0;
   endtask

   // in_valid and out_ready held high. Records 0x10..0x19 leave in order and
   // each appears one cycle after its push. Occupancy sits at 1.
   task automatic test_streaming();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (i > 0) begin
            n_cmp++; if (od2 !== 97'(8'h10 + i - 1) || cnt2 !== 2'd1) begin n_err++; $display("FAIL stream_%0d: got data %h count %0d want %h 1", i - 1, od2, cnt2, 8'h10 + i - 1); end
         end
         iv2 = 1'b1; or2 = 1'b1; id2 = 97'(8'h10 + i);
      end
      @(negedge clk);
      n_cmp++; if (od2 !== 97'h19 || cnt2 !== 2'd1) begin n_err++; $display("FAIL stream_last: got data %h count %0d want 19 1", od2, cnt2); end
      iv2 = 1'b0;
      @(negedge clk);
      n_cmp++; if (cnt2 !== 2'd0 || ov2 !== 1'b0) begin n_err++; $display("FAIL stream_drain: got count %0d valid %b want 0 0", cnt2, ov2); end
      or2 = 1'b0;
   endtask

   // Flush while full, with a push and a pop offered. Everything is dropped and
   // a later push of 0x7 is the first record out.
   task automatic test_flush();
      @(negedge clk); iv2 = 1'b1; id2 = 97'hA; or2 = 1'b0;
      @(negedge clk); id2 = 97'hB;
      @(negedge clk);
      n_cmp++; if (cnt2 !== 2'd2) begin n_err++; $display("FAIL flush_pre_count: got %0d want 2", cnt2); end
      fl2 = 1'b1; iv2 = 1'b1; id2 = 97'h55; or2 = 1'b1;
      #1;
      n_cmp++; if (ir2 !== 1'b0 || ov2 !== 1'b1) begin n_err++; $display("FAIL flush_cycle_status: got ready %b valid %b want 0 1", ir2, ov2); end
      @(negedge clk);
      n_cmp++; if (cnt2 !== 2'd0 || ov2 !== 1'b0 || od2 !== 97'h0 || ir2 !== 1'b1) begin n_err++; $display("FAIL flush_after: got count %0d valid %b data %h ready %b want 0 0 0 1", cnt2, ov2, od2, ir2); end
      fl2 = 1'b0; iv2 = 1'b1; id2 = 97'h7; or2 = 1'b0;
      @(negedge clk);
      n_cmp++; if (od2 !== 97'h7 || cnt2 !== 2'd1) begin n_err++; $display("FAIL flush_repush: got data %h count %0d want 7 1", od2, cnt2); end
      iv2 = 1'b0; or2 = 1'b1;
      @(negedge clk);
      n_cmp++; if (cnt2 !== 2'd0) begin n_err++; $display("FAIL flush_drain: got count %0d want 0", cnt2); end
      or2 = 1'b0;
   endtask

   // Fill to 2, then assert reset between edges. Outputs clear before the next edge.
   task automatic test_async_reset();
      @(negedge clk); iv2 = 1'b1; id2 = 97'h21; or2 = 1'b0;
      @(negedge clk); id2 = 97'h22;
      @(negedge clk);
      iv2 = 1'b0;
      n_cmp++; if (cnt2 !== 2'd2) begin n_err++; $display("FAIL areset_pre: got count %0d want 2", cnt2); end
      #2 reset = 1'b0;
      #1;
      n_cmp++; if (ov2 !== 1'b0 || ir2 !== 1'b1 || cnt2 !== 2'd0 || od2 !== 97'h0) begin n_err++; $display("FAIL areset_immediate: got valid %b ready %b count %0d data %h want 0 1 0 0", ov2, ir2, cnt2, od2); end
      #1 reset = 1'b1;
      @(negedge clk);
      n_cmp++; if (cnt2 !== 2'd0 || ov2 !== 1'b0) begin n_err++; $display("FAIL areset_after: got count %0d valid %b want 0 0", cnt2, ov2); end
   endtask

   // DEPTH=3. Seven pushes interleaved with pops so that both pointers pass
   // slot 2 and wrap to 0. Rows give the inputs for the next edge and the
   // expected outputs sampled after it.
   task automatic test_wrap();
      logic        t_iv [11] = '{1, 1, 1, 0, 1, 1, 1, 1, 0, 0, 0};
      logic        t_or [11] = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 0};
      logic [15:0] t_d  [11] = '{16'h21, 16'h22, 16'h23, 16'h0, 16'h24, 16'h25, 16'h26, 16'h27, 16'h0, 16'h0, 16'h0};
      logic [1:0]  e_c  [11] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd0, 2'd0};
      logic [15:0] e_d  [11] = '{16'h21, 16'h21, 16'h21, 16'h22, 16'h23, 16'h24, 16'h25, 16'h26, 16'h27, 16'h0, 16'h0};
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         iv3 = t_iv[i]; or3 = t_or[i]; id3 = t_d[i];
         @(negedge clk);
         n_cmp++; if (cnt3 !== e_c[i] || od3 !== e_d[i]) begin n_err++; $display("FAIL wrap_step%0d: got count %0d data %h want %0d %h", i, cnt3, od3, e_c[i], e_d[i]); end
         if (i == 2) begin
            n_cmp++; if (ir3 !== 1'b0) begin n_err++; $display("FAIL wrap_full_ready: got %b want 0", ir3); end
         end
         iv3 = 1'b0; or3 = 1'b0;
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_full_pop();
      test_streaming();
      test_flush();
      test_async_reset();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pipe_stage_fifo.md
# pipe_stage_fifo

Parametrised elastic pipeline buffer placed between two CPU pipeline stages, such as fetch→decode or decode→execute, replacing the single-entry stage register. It stores up to DEPTH packed stage records of WIDTH bits and moves them in order using a valid/ready handshake in both directions. It supports a single-cycle flush for branch or jump redirects. All outputs are registered-state driven, so there is no combinational path from the upstream inputs to the downstream outputs.

## Interface
- WIDTH, 97, payload width in bits (default holds valid + 32-bit raw_instr + 64-bit pc of a fetch record); ≥1
- DEPTH, 2, number of entries; ≥2, not required to be a power of two
- CW (derived), $clog2(DEPTH+1), width of the occupancy count
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low; asserting it (0) clears all state immediately
- in_valid  input  1  upstream offers in_data this cycle
- in_ready  output  1  buffer can accept; equals (count != DEPTH)
- in_data  input  WIDTH  upstream stage record
- out_valid  output  1  head entry is present; equals (count != 0)
- out_ready  input  1  downstream consumes the head this cycle
- out_data  output  WIDTH  head entry; all-zero when out_valid = 0
- flush  input  1  discard every stored entry and any push in this cycle
- count  output  CW  current occupancy, 0..DEPTH

## Operation
- State:
  - storage array mem[0..DEPTH-1]
  - write pointer wr_ptr and read pointer rd_ptr, each $clog2(DEPTH) bits
  - occupancy register count
- Definitions:
  - push = in_valid & in_ready & !flush
  - pop = out_valid & out_ready & !flush
- On push: mem[wr_ptr] <= in_data, and wr_ptr advances.
- On pop: rd_ptr advances.
- Pointer advance wraps explicitly: DEPTH-1 → 0. Modulo-2^n wrap is not allowed, because DEPTH may not be a power of two.
- count update:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged
  - neither: unchanged
- Full (count = DEPTH):
  - in_ready = 0, so no push can occur, even if a pop happens in the same cycle.
  - The freed slot becomes usable on the next cycle.
- Empty (count = 0):
  - out_valid = 0 and out_data = 0.
  - A push in this cycle is not forwarded; it becomes visible next cycle.
- flush = 1:
  - Next edge: count <= 0, wr_ptr <= 0, rd_ptr <= 0.
  - in_valid and out_ready are ignored in that cycle.
  - in_ready and out_valid are not gated by flush in the flush cycle itself; they are derived from count only.
  - mem contents are not cleared.
- Reset asserted: count, wr_ptr and rd_ptr are 0 immediately, independent of clk. mem is cleared to 0.
- Reset deasserted: the first state update happens on the next rising edge.
- Reset asserted mid-operation loses all entries; the upstream stage must re-supply them.
- Entry order is strictly FIFO. There is no reordering, no bypass, and no partial flush.

## Timing
- Reset values:
  - in_ready = 1
  - out_valid = 0
  - out_data = 0
  - count = 0
- Latency: a record pushed at edge t appears on out_data, with out_valid = 1, right after edge t (cycle t+1) when the buffer was empty. Otherwise it appears after all older entries pop.
- Throughput: one push and one pop per cycle, sustained, when 0 < count < DEPTH.
- The buffer is full-rate at DEPTH=2 with out_ready held high.
- in_ready and out_valid are functions of count only, which gives registered-output timing.
- out_data is a mux of mem by rd_ptr, gated by out_valid.
- Flush takes effect in one cycle: the cycle after flush, out_valid = 0 and in_ready = 1.

## Test plan
- Reset, then fill at DEPTH=2: push A=0x1, B=0x2 on consecutive cycles, out_ready=0 → count=2, in_ready=0, out_data=0x1.
- Streaming: in_valid and out_ready both held high, 10 records 0x10..0x19 → out_data is 0x10..0x19 in order, each one cycle after its push, and count stays 1.
- Full plus pop: at count=2 assert in_valid=1 (C=0x3) and out_ready=1 → A pops, C is not accepted, count=1. Next cycle C is accepted and count=2.
- Flush with simultaneous push and pop: count=2, flush=1, in_valid=1, out_ready=1 → next cycle count=0, out_valid=0, out_data=0. A subsequent push of 0x7 emerges first.
- DEPTH=3 wrap: 7 pushes interleaved with pops to cycle the pointers past index 2 → data order is preserved across the 2→0 wrap, and count never exceeds 3.
- Asynchronous reset mid-stream: drop reset between edges while count=2 → out_valid=0, in_ready=1 and count=0 before the next edge.
